// File: rtl/laser500_ram_arbiter.sv
// Shares the single SDRAM port between ROM download, VTL video fetch and the Z80.
// Each access holds the port for ACC_CYCLES cycles, then pulses one ack in a DONE cycle.
module laser500_ram_arbiter #(
  parameter int ACC_CYCLES = 4,
  parameter int CPU_STARVE = 2,
  parameter int AW         = 25
) (
  input  logic          F14M,
  input  logic          RESET,
  input  logic          dio_req,
  input  logic [AW-1:0] dio_addr,
  input  logic [7:0]    dio_data,
  output logic          dio_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_wait_n,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  output logic          ram_oe,
  input  logic [7:0]    ram_dout
);

  localparam int CW = $clog2(ACC_CYCLES + 1);
  localparam int SW = $clog2(CPU_STARVE + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {G_DIO, G_VID, G_CPU} grant_t;

  state_t        state;
  grant_t        grant;
  grant_t        grant_sel;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;

  // dio always wins; the CPU overtakes video once it has been starved long enough
  always_comb begin
    grant_sel = G_VID;
    if (dio_req)
      grant_sel = G_DIO;
    else if (cpu_req && (starve_cnt == SW'(CPU_STARVE) || !vid_req))
      grant_sel = G_CPU;
  end

  // RESET forces the Z80 out of wait even while its request is still asserted
  assign cpu_wait_n = RESET | ~(cpu_req & ~cpu_ack);

  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      grant      <= G_DIO;
      cnt        <= '0;
      starve_cnt <= '0;
      dio_ack    <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_data   <= 8'h00;
      cpu_rdata  <= 8'h00;
      ram_addr   <= '0;
      ram_din    <= 8'h00;
      ram_we     <= 1'b0;
      ram_oe     <= 1'b0;
    end else begin
      dio_ack <= 1'b0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      if (!cpu_req)
        starve_cnt <= '0;

      case (state)
        IDLE: begin
          if (dio_req || vid_req || cpu_req) begin
            grant  <= grant_sel;
            ram_oe <= 1'b1;
            cnt    <= CW'(ACC_CYCLES - 1);
            state  <= ACCESS;
            case (grant_sel)
              G_DIO: begin
                ram_addr <= dio_addr;
                ram_din  <= dio_data;
                ram_we   <= 1'b1;
              end
              G_CPU: begin
                ram_addr   <= cpu_addr;
                ram_din    <= cpu_wdata;
                ram_we     <= cpu_we;
                starve_cnt <= '0;
              end
              default: begin
                ram_addr <= vid_addr;
                ram_din  <= 8'h00;
                ram_we   <= 1'b0;
                if (cpu_req && starve_cnt != SW'(CPU_STARVE))
                  starve_cnt <= starve_cnt + 1'b1;
              end
            endcase
          end
        end

        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            ram_oe <= 1'b0;
            ram_we <= 1'b0;
            // ram_we is still the latched direction here, so writes skip the capture
            case (grant)
              G_DIO: dio_ack <= 1'b1;
              G_CPU: begin
                cpu_ack <= 1'b1;
                if (!ram_we)
                  cpu_rdata <= ram_dout;
              end
              default: begin
                vid_ack  <= 1'b1;
                vid_data <= ram_dout;
              end
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
